uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Shares one UART serial TX line among NUM_REQ byte requesters using round-robin arbitration.
- Serializes each granted byte as an 8N1 frame, one bit per baud_tick pulse.
- Sits downstream of the baud tick generator (its tx tick output drives baud_tick) and upstream of the UART pad.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data bits per frame (LSB first).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-cycle bit-rate strobe from the baud generator.
- req  input  NUM_REQ  per-requester send request; level, held until ack.
- req_data  input  NUM_REQ*DATA_W  flattened bytes; requester i uses bits [i*DATA_W +: DATA_W].
- ack  output  NUM_REQ  one-hot, one-cycle pulse when that requester's byte is latched.
- grant_id  output  clog2(NUM_REQ)  index of requester currently being sent.
- busy  output  1  high from grant until end of stop bit.
- tx  output  1  serial line; idle high.

Behaviour:
- Reset is synchronous, active-high; one clock; all state updates on posedge clk.
- Reset values: tx=1, ack=0, busy=0, grant_id=0, state=IDLE, bit_cnt=0, shift reg=0, rr_ptr=NUM_REQ-1 (requester 0 has first priority).
- Reset mid-frame aborts the frame: tx=1 at the reset edge, and no ack is issued for the aborted request.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
- All state and tx changes occur only on cycles with baud_tick=1; every cycle with baud_tick high counts as one tick.
- IDLE, tick with any req bit set:
  - Arbitrate and latch req_data of the winner into the shift reg.
  - Pulse ack[winner] for exactly one cycle (registered at this edge).
  - Set grant_id=winner, rr_ptr=winner, busy=1, tx=0 (start bit), then go to START.
- IDLE, tick with req=0: stay in IDLE with tx=1.
- IDLE, req asserted with no tick: wait; no ack.
- START, on tick: tx=shift[0], bit_cnt=0, go to DATA.
- DATA, on tick:
  - If bit_cnt==DATA_W-1: tx=1 (stop bit), go to STOP.
  - Otherwise: shift right, tx=next bit, bit_cnt+1.
- STOP, on tick:
  - If any req is set: arbitrate as in IDLE and go to START (back-to-back, no idle gap).
  - Otherwise: busy=0, tx=1, go to IDLE.
- Frame length is exactly DATA_W+2 ticks. tx is registered and never glitches between ticks.
- Round-robin:
  - Search starts at rr_ptr+1 and wraps modulo NUM_REQ; the first set req wins.
  - A lone requester is served on consecutive frames.
- Requesters must hold req and data stable until ack. If req drops before grant, it is not served and ack is not issued.
- The data of a granted request is captured at grant; later changes to req_data do not affect the frame.
- req still high the cycle after ack is treated as a new request.
- No ack is issued while a frame is in progress except at STOP-tick re-arbitration.
- grant_id holds its last value while idle.

Optional Feature:
- Macro: UART_TX_SCHED_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - On the last DATA tick, tx = even parity (XOR of the latched byte); the next tick drives the stop bit.
  - Frame is DATA_W+3 ticks.
- Undefined: no PARITY state; 8N1 frames as above.

Test Plan:
- Reset then idle: req=0, 20 ticks -> tx=1, busy=0, ack=0 throughout.
- Single send: req[2]=1, data2=8'hA5, tick every 16 clks ->
  - ack[2] pulses once on the first tick and grant_id=2.
  - tx bit sequence 0,1,0,1,0,0,1,0,1,1 (11 with parity on: parity bit 0 before the stop bit).
  - busy falls on the tick after the stop bit.
- Round-robin: req=4'b1111 held, re-asserted after each ack -> grant order 0,1,2,3,0; frames back-to-back with no idle tick between stop and start.
- Fairness wrap: rr_ptr=3, req=4'b1001 -> requester 0 wins, then requester 3.
- Tick gating: req[1]=1 with no baud_tick for 50 clks -> no ack and tx=1; first tick -> ack[1] and tx=0.
- Reset mid-frame: assert reset during DATA bit 4 of 8'h3C -> tx=1, busy=0, ack=0 next edge; a held req is re-served from the start bit after reset deasserts.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART TX line among NUM_REQ requesters.
// Optional even parity bit when UART_TX_SCHED_PARITY_EN is defined.
`timescale 1ns/1ps

module uart_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       baud_tick,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       tx
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_SCHED_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t              r_state;
    state_t              w_nxt_state;

    logic                r_tx;
    logic [DATA_W-1:0]   r_shift;
    logic [CW-1:0]       r_cnt;
    logic [NUM_REQ-1:0]  r_ack;
    logic                r_busy;
    logic [IDW-1:0]      r_gid;
    logic [IDW-1:0]      r_rr;

    logic                w_tx_d;
    logic [DATA_W-1:0]   w_shift_d;
    logic [CW-1:0]       w_cnt_d;
    logic [NUM_REQ-1:0]  w_ack_d;
    logic                w_busy_d;
    logic [IDW-1:0]      w_gid_d;
    logic [IDW-1:0]      w_rr_d;

    logic                w_found;
    logic [IDW-1:0]      w_winner;
    logic [DATA_W-1:0]   w_sel;
    logic                w_last;

`ifdef UART_TX_SCHED_PARITY_EN
    logic                r_par;
    logic                w_par_d;
`endif

    assign w_last = (r_cnt == CW'(DATA_W - 1));

    // Round-robin search from rr_ptr+1; the nearest set request wins.
    always_comb begin
        logic [IDW-1:0] idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDW'((int'(r_rr) + k) % NUM_REQ);
            if (req[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    // Select the winner's byte from the flattened data bus.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDW'(i)) begin
                w_sel = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register and all datapath registers; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_shift <= '0;
            r_cnt   <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_gid   <= '0;
            r_rr    <= IDW'(NUM_REQ - 1);
`ifdef UART_TX_SCHED_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_nxt_state;
            r_tx    <= w_tx_d;
            r_shift <= w_shift_d;
            r_cnt   <= w_cnt_d;
            r_ack   <= w_ack_d;
            r_busy  <= w_busy_d;
            r_gid   <= w_gid_d;
            r_rr    <= w_rr_d;
`ifdef UART_TX_SCHED_PARITY_EN
            r_par   <= w_par_d;
`endif
        end
    end

    // Next-state logic; the FSM only advances on baud ticks.
    always_comb begin
        w_nxt_state = r_state;
        if (baud_tick) begin
            unique case (r_state)
                S_IDLE:  w_nxt_state = w_found ? S_START : S_IDLE;
                S_START: w_nxt_state = S_DATA;
`ifdef UART_TX_SCHED_PARITY_EN
                S_DATA:   w_nxt_state = w_last ? S_PARITY : S_DATA;
                S_PARITY: w_nxt_state = S_STOP;
`else
                S_DATA:  w_nxt_state = w_last ? S_STOP : S_DATA;
`endif
                S_STOP:  w_nxt_state = w_found ? S_START : S_IDLE;
                default: w_nxt_state = S_IDLE;
            endcase
        end
    end

    // Output/datapath next values: grant, shifting and line level.
    always_comb begin
        w_tx_d    = r_tx;
        w_shift_d = r_shift;
        w_cnt_d   = r_cnt;
        w_ack_d   = '0;
        w_busy_d  = r_busy;
        w_gid_d   = r_gid;
        w_rr_d    = r_rr;
`ifdef UART_TX_SCHED_PARITY_EN
        w_par_d   = r_par;
`endif
        if (baud_tick) begin
            unique case (r_state)
                S_IDLE, S_STOP: begin
                    if (w_found) begin
                        w_shift_d = w_sel;
                        w_ack_d   = NUM_REQ'(1) << w_winner;
                        w_gid_d   = w_winner;
                        w_rr_d    = w_winner;
                        w_busy_d  = 1'b1;
                        w_tx_d    = 1'b0;
`ifdef UART_TX_SCHED_PARITY_EN
                        w_par_d   = ^w_sel;
`endif
                    end else begin
                        w_busy_d = 1'b0;
                        w_tx_d   = 1'b1;
                    end
                end
                S_START: begin
                    w_tx_d  = r_shift[0];
                    w_cnt_d = '0;
                end
                S_DATA: begin
                    if (w_last) begin
`ifdef UART_TX_SCHED_PARITY_EN
                        w_tx_d = r_par;
`else
                        w_tx_d = 1'b1;
`endif
                    end else begin
                        w_shift_d = r_shift >> 1;
                        w_tx_d    = w_shift_d[0];
                        w_cnt_d   = r_cnt + CW'(1);
                    end
                end
`ifdef UART_TX_SCHED_PARITY_EN
                S_PARITY: w_tx_d = 1'b1;
`endif
                default: w_tx_d = 1'b1;
            endcase
        end
    end

    assign tx       = r_tx;
    assign ack      = r_ack;
    assign busy     = r_busy;
    assign grant_id = r_gid;

endmodule
